branch_resolve: RTL
===================

// Module: branch_resolve
// PURPOSE
//   Branch resolution unit for the RV32I core: the consumer side of the branch comparator.
//   Accepts B-type ops from decode and drives the comparator's unsigned/signed select.
//   Turns the comparator's less/equal flags into a taken decision, target PC, mispredict flag and flush pulse.
//   Registers the result toward fetch and holds off new ops for a fixed refill window after a flush.
//   Also keeps saturating branch/taken counters for performance monitoring.
// PARAMETERS
//   FLUSH_CYC  2   cycles o_ready is held low after a flush pulse (1..15)
//   CNT_W      16  width of the performance counters
// PORTS
//   i_clk          in   1      clock; all state updates on rising edge
//   i_rst          in   1      reset: synchronous, active-high
//   i_valid        in   1      branch op valid
//   o_ready        out  1      unit can accept an op this cycle
//   i_pc           in   32     PC of the branch
//   i_imm          in   32     sign-extended B-type offset
//   i_funct3       in   3      branch funct3
//   i_pred_taken   in   1      fetch prediction for this branch
//   o_br_un        out  1      to comparator: 1 = signed compare, 0 = unsigned compare
//   i_br_less      in   1      from comparator: rs1 < rs2 under o_br_un mode
//   i_br_equal     in   1      from comparator: rs1 == rs2
//   o_res_valid    out  1      result register holds a valid result
//   i_res_ready    in   1      fetch consumes the result
//   o_taken        out  1      resolved direction
//   o_redirect_pc  out  32     taken ? pc+imm : pc+4
//   o_mispredict   out  1      resolved direction != i_pred_taken (legal ops only)
//   o_misalign     out  1      taken && target[1:0] != 0
//   o_illegal      out  1      funct3 is 010 or 011
//   o_flush        out  1      one-cycle pulse on mispredict load
//   i_cnt_clr      in   1      synchronous clear of both counters
//   o_branch_cnt   out  CNT_W  legal branches accepted, saturating
//   o_taken_cnt    out  CNT_W  taken branches accepted, saturating
// BEHAVIOUR
//   Reset: all outputs 0 except o_ready=1 and o_br_un=0. FSM=RUN. Counters=0. Result register empty.
//   o_br_un (combinational from i_funct3): 1 for 100/101 (BLT/BGE), 0 for all other codes.
//     The comparator answers in the same cycle.
//   Decode:
//     000 taken=eq; 001 taken=!eq
//     100/110 taken=less; 101/111 taken=!less
//     010/011 taken=0, illegal=1
//   Accept = i_valid && o_ready.
//     o_ready = (state==RUN) && (!o_res_valid || i_res_ready).
//     Pipelined: accept and consume can occur in the same cycle.
//   On accept, next edge loads the result register:
//     o_taken, o_redirect_pc, o_mispredict, o_misalign, o_illegal; o_res_valid=1.
//     Latency 1 cycle from accept to o_res_valid.
//   Address arithmetic: pc+imm and pc+4 are 32-bit modulo (wrap, no overflow flag).
//   o_res_valid clears on consume (o_res_valid && i_res_ready) with no accept in the same cycle.
//   Outputs hold stable while o_res_valid && !i_res_ready.
//   o_flush = 1 for exactly the cycle after loading a result with mispredict=1.
//     It does not repeat while the result stalls.
//   FSM:
//     RUN -> FLUSH on loading a mispredicted result; the down-counter loads FLUSH_CYC.
//     FLUSH: o_ready=0; counter decrements each cycle; at 1 -> RUN.
//     Illegal and misaligned results never flush.
//   Counters, on accept:
//     o_branch_cnt += 1 if legal; o_taken_cnt += 1 if taken.
//     Both saturate at all-ones.
//     i_cnt_clr has priority over an increment in the same cycle.
//   i_rst mid-operation: discards the held result and any FLUSH window; returns to reset state next cycle.
//   i_valid while !o_ready: the op is not consumed; upstream holds it.
// TESTING
//   BEQ, rs1==rs2 (equal=1), pc=0x100, imm=0x20, pred=0
//     -> o_br_un=0; next cycle taken=1, redirect=0x120, mispredict=1, flush pulse;
//        o_ready low 2 cycles.
//   BLT, less=1, pred=1, pc=0x200, imm=-8
//     -> o_br_un=1; taken=1, redirect=0x1F8, no flush, o_ready stays 1.
//   BGEU, less=0, pc=0xFFFFFFFC, imm=8
//     -> o_br_un=0; taken=1, redirect=0x00000004 (wrap).
//   funct3=010
//     -> illegal=1, taken=0, redirect=pc+4, no flush, branch_cnt unchanged.
//   Back-to-back ops with i_res_ready=0 on the 2nd
//     -> o_ready=0 and result held stable; i_res_ready=1 -> consume and accept in the same cycle.
//   Counter load 0xFFFF then 1 taken branch
//     -> stays 0xFFFF; i_cnt_clr + accept in the same cycle -> 0.
//   i_rst during FLUSH
//     -> next cycle o_ready=1, o_res_valid=0.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution unit: drives the comparator mode, turns its flags into a taken
// decision and redirect PC, registers the result toward fetch and holds off new ops during refill.
module branch_resolve #(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic [2:0]       i_funct3,
    input  logic             i_pred_taken,
    output logic             o_br_un,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_taken,
    output logic [31:0]      o_redirect_pc,
    output logic             o_mispredict,
    output logic             o_misalign,
    output logic             o_illegal,
    output logic             o_flush,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic             o_fsm_state
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic        taken, illegal, mispredict, misalign, flush_req, accept;
    logic [31:0] target, seq_pc;

    // Handshakes: an op transfers when i_valid && o_ready; a result transfers when
    // o_res_valid && i_res_ready. Both may happen in the same cycle.
    assign o_br_un = (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    assign target  = i_pc + i_imm;
    assign seq_pc  = i_pc + 32'd4;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (i_funct3)
            3'b000:          taken = i_br_equal;
            3'b001:          taken = !i_br_equal;
            3'b100, 3'b110:  taken = i_br_less;
            3'b101, 3'b111:  taken = !i_br_less;
            default:         illegal = 1'b1;
        endcase
    end

    assign mispredict = !illegal && (taken != i_pred_taken);
    assign misalign   = taken && (target[1:0] != 2'b00);
    // A misaligned target traps instead of refetching, so it never opens a refill window.
    assign flush_req  = mispredict && !misalign;
    assign o_ready    = (state == RUN) && (!o_res_valid || i_res_ready);
    assign accept     = i_valid && o_ready;
    assign o_fsm_state = state;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            RUN: begin
                if (accept && flush_req) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = 4'(FLUSH_CYC);
                end
            end
            FLUSH: begin
                if (flush_cnt <= 4'd1) begin
                    state_nxt     = RUN;
                    flush_cnt_nxt = 4'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt     = RUN;
                flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_valid   <= 1'b0;
            o_taken       <= 1'b0;
            o_redirect_pc <= 32'd0;
            o_mispredict  <= 1'b0;
            o_misalign    <= 1'b0;
            o_illegal     <= 1'b0;
            o_flush       <= 1'b0;
        end else begin
            o_flush <= accept && flush_req;
            if (accept) begin
                o_res_valid   <= 1'b1;
                o_taken       <= taken;
                o_redirect_pc <= taken ? target : seq_pc;
                o_mispredict  <= mispredict;
                o_misalign    <= misalign;
                o_illegal     <= illegal;
            end else if (o_res_valid && i_res_ready) begin
                o_res_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            o_branch_cnt <= '0;
            o_taken_cnt  <= '0;
        end else if (accept) begin
            if (!illegal && (o_branch_cnt != '1))
                o_branch_cnt <= o_branch_cnt + 1'b1;
            if (taken && (o_taken_cnt != '1))
                o_taken_cnt <= o_taken_cnt + 1'b1;
        end
    end

endmodule
